// File: rtl/ordenador_serial.sv
// Streaming insertion sorter: loads a batch of DEPTH words, keeping them ranked
// as they arrive, then emits the ranked batch over a valid/ready output.
module ordenador_serial #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned DEPTH = 3,
    parameter bit          ORDER = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             out_last
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);
    localparam logic [IW-1:0] IDX_LAST = IW'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [WIDTH-1:0] sort_q [DEPTH];
    logic [WIDTH-1:0] sort_d [DEPTH];

    logic [DEPTH-1:0] ahead_s;
    logic [DEPTH-1:0] lead_s;
    logic [WIDTH-1:0] prev_s [DEPTH];
    logic [WIDTH-1:0] ins_s  [DEPTH];
    logic             accept_s;
    logic             take_s;

    assign in_ready  = (state_q == ST_LOAD);
    assign out_valid = (state_q == ST_EMIT);
    assign out_data  = sort_q[idx_q];
    assign out_last  = (state_q == ST_EMIT) && (idx_q == IDX_LAST);
    assign accept_s  = in_valid && (state_q == ST_LOAD);
    assign take_s    = out_ready && (state_q == ST_EMIT);

    // Rank test: a valid entry stays ahead of the new word, equal entries included so ties stay in arrival order.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) < cnt_q) begin
                if (ORDER == 1'b0) begin
                    ahead_s[j] = (sort_q[j] >= in_data);
                end else begin
                    ahead_s[j] = (sort_q[j] <= in_data);
                end
            end else begin
                ahead_s[j] = 1'b0;
            end
        end
    end

    // Neighbour views: lead_s marks the slot just behind the last entry that stays ahead.
    always_comb begin
        lead_s[0] = 1'b1;
        prev_s[0] = in_data;
        for (int j = 1; j < DEPTH; j++) begin
            lead_s[j] = ahead_s[j-1];
            prev_s[j] = sort_q[j-1];
        end
    end

    // Single-cycle insertion: keep the front, drop the word in, shift the tail down by one.
    always_comb begin
        for (int j = 0; j < DEPTH; j++) begin
            if (CW'(j) > cnt_q) begin
                ins_s[j] = sort_q[j];
            end else if (ahead_s[j]) begin
                ins_s[j] = sort_q[j];
            end else if (lead_s[j]) begin
                ins_s[j] = in_data;
            end else begin
                ins_s[j] = prev_s[j];
            end
        end
    end

    // Next-state logic for the load/emit sequencer and its counters.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        sort_d  = sort_q;
        case (state_q)
            ST_LOAD: begin
                if (accept_s) begin
                    sort_d = ins_s;
                    cnt_d  = cnt_q + CW'(1);
                    if (cnt_q == CNT_LAST) begin
                        state_d = ST_EMIT;
                    end else begin
                        state_d = ST_LOAD;
                    end
                end else begin
                    state_d = ST_LOAD;
                end
            end
            ST_EMIT: begin
                if (take_s) begin
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_LOAD;
                        idx_d   = {IW{1'b0}};
                        cnt_d   = {CW{1'b0}};
                    end else begin
                        idx_d   = idx_q + IW'(1);
                    end
                end else begin
                    state_d = ST_EMIT;
                end
            end
            default: begin
                state_d = ST_LOAD;
                idx_d   = {IW{1'b0}};
                cnt_d   = {CW{1'b0}};
            end
        endcase
    end

    // State, counter and storage registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_LOAD;
            cnt_q   <= {CW{1'b0}};
            idx_q   <= {IW{1'b0}};
            for (int j = 0; j < DEPTH; j++) begin
                sort_q[j] <= {WIDTH{1'b0}};
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            for (int j = 0; j < DEPTH; j++) begin
                sort_q[j] <= sort_d[j];
            end
        end
    end

endmodule

// File: tb/tb_ordenador_serial.sv
// Self-checking bench for ordenador_serial: directed vector table, hand sequences
// for ascending back-to-back batches, and randomized batches against a ranking model.
module tb_ordenador_serial;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // d0: WIDTH=4 DEPTH=3 descending
    logic       a_iv = 1'b0, a_ordy = 1'b0, a_ir, a_ov, a_ol;
    logic [3:0] a_id = 4'd0, a_od;
    // d1: WIDTH=4 DEPTH=4 ascending
    logic       b_iv = 1'b0, b_ordy = 1'b0, b_ir, b_ov, b_ol;
    logic [3:0] b_id = 4'd0, b_od;
    // d2/d3: WIDTH=8 DEPTH=8, shared stimulus, descending and ascending
    logic       r_iv = 1'b0, r_ordy = 1'b0;
    logic [7:0] r_id = 8'd0;
    logic       c_ir, c_ov, c_ol, e_ir, e_ov, e_ol;
    logic [7:0] c_od, e_od;

    ordenador_serial #(.WIDTH(4), .DEPTH(3), .ORDER(1'b0)) d0 (
        .clk(clk), .rst(rst), .in_valid(a_iv), .in_data(a_id), .in_ready(a_ir),
        .out_valid(a_ov), .out_data(a_od), .out_ready(a_ordy), .out_last(a_ol));
    ordenador_serial #(.WIDTH(4), .DEPTH(4), .ORDER(1'b1)) d1 (
        .clk(clk), .rst(rst), .in_valid(b_iv), .in_data(b_id), .in_ready(b_ir),
        .out_valid(b_ov), .out_data(b_od), .out_ready(b_ordy), .out_last(b_ol));
    ordenador_serial #(.WIDTH(8), .DEPTH(8), .ORDER(1'b0)) d2 (
        .clk(clk), .rst(rst), .in_valid(r_iv), .in_data(r_id), .in_ready(c_ir),
        .out_valid(c_ov), .out_data(c_od), .out_ready(r_ordy), .out_last(c_ol));
    ordenador_serial #(.WIDTH(8), .DEPTH(8), .ORDER(1'b1)) d3 (
        .clk(clk), .rst(rst), .in_valid(r_iv), .in_data(r_id), .in_ready(e_ir),
        .out_valid(e_ov), .out_data(e_od), .out_ready(r_ordy), .out_last(e_ol));

    typedef struct {
        logic       rst;
        logic       iv;
        logic [3:0] id;
        logic       ordy;
        logic       ir;
        logic       ov;
        logic [3:0] od;
        logic       ol;
    } vec_t;
    vec_t vecs[$];

    typedef logic [7:0] batch_t [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic void add(input int rs, input int iv, input int id, input int ordy,
                                input int ir, input int ov, input int od, input int ol);
        vec_t v;
        v.rst = rs[0]; v.iv = iv[0]; v.id = id[3:0]; v.ordy = ordy[0];
        v.ir = ir[0]; v.ov = ov[0]; v.od = od[3:0]; v.ol = ol[0];
        vecs.push_back(v);
    endfunction

    // Ranking model: repeatedly pull the first best word, which is a stable sort.
    function automatic batch_t ranked(input logic [7:0] words[$], input bit asc);
        batch_t res;
        logic [7:0] w[$];
        int best;
        w = words;
        for (int k = 0; k < 8; k++) begin
            best = 0;
            for (int m = 1; m < w.size(); m++) begin
                if (asc ? (w[m] < w[best]) : (w[m] > w[best])) best = m;
            end
            res[k] = w[best];
            w.delete(best);
        end
        return res;
    endfunction

    initial begin
        logic [3:0] b_in  [8];
        logic [3:0] b_exp [8];
        logic [7:0] words[$];
        batch_t     exp_dn, exp_up;
        bit         loading;
        int         pos, done, cyc;

        // rst iv id ordy | ir ov od ol
        add(0,1,5,1, 1,0,0,0);  add(0,1,9,1, 1,0,5,0);  add(0,1,2,1, 1,0,9,0);
        add(0,0,0,1, 0,1,9,0);  add(0,0,0,1, 0,1,5,0);  add(0,0,0,1, 0,1,2,1);
        add(0,1,7,1, 1,0,9,0);  add(0,1,0,1, 1,0,7,0);  add(0,1,7,1, 1,0,7,0);
        add(0,1,3,1, 0,1,7,0);  add(0,0,0,1, 0,1,7,0);  add(0,0,0,1, 0,1,0,1);
        add(0,1,15,1, 1,0,7,0); add(0,1,15,1, 1,0,15,0); add(0,1,15,1, 1,0,15,0);
        add(0,0,0,1, 0,1,15,0); add(0,0,0,1, 0,1,15,0); add(0,0,0,1, 0,1,15,1);
        add(0,1,3,0, 1,0,15,0); add(0,1,1,0, 1,0,3,0);  add(0,1,2,0, 1,0,3,0);
        for (int i = 0; i < 4; i++) add(0,1,8,0, 0,1,3,0);
        add(0,1,8,1, 0,1,3,0);  add(0,1,8,0, 0,1,2,0);  add(0,0,0,1, 0,1,2,0);
        add(0,1,8,1, 0,1,1,1);  add(0,0,0,0, 1,0,3,0);
        add(0,1,6,0, 1,0,3,0);  add(0,1,3,0, 1,0,6,0);  add(1,0,0,0, 1,0,6,0);
        add(0,1,1,1, 1,0,0,0);  add(0,1,8,1, 1,0,1,0);  add(0,1,5,1, 1,0,8,0);
        add(0,0,0,1, 0,1,8,0);  add(0,0,0,1, 0,1,5,0);  add(0,0,0,1, 0,1,1,1);
        add(0,1,6,1, 1,0,8,0);  add(0,1,3,1, 1,0,6,0);  add(0,1,9,1, 1,0,6,0);
        add(0,0,0,1, 0,1,9,0);  add(1,0,0,0, 0,1,6,0);
        add(0,1,1,1, 1,0,0,0);  add(0,1,8,1, 1,0,1,0);  add(0,1,5,1, 1,0,8,0);
        add(0,0,0,1, 0,1,8,0);  add(0,0,0,1, 0,1,5,0);  add(0,0,0,1, 0,1,1,1);
        add(0,0,0,0, 1,0,8,0);

        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            rst = vecs[i].rst; a_iv = vecs[i].iv; a_id = vecs[i].id; a_ordy = vecs[i].ordy;
            @(negedge clk);
            check($sformatf("vec%0d_in_ready", i),  32'(a_ir), 32'(vecs[i].ir));
            check($sformatf("vec%0d_out_valid", i), 32'(a_ov), 32'(vecs[i].ov));
            check($sformatf("vec%0d_out_data", i),  32'(a_od), 32'(vecs[i].od));
            check($sformatf("vec%0d_out_last", i),  32'(a_ol), 32'(vecs[i].ol));
            @(posedge clk);
            #1;
        end
        rst = 1'b0; a_iv = 1'b0; a_ordy = 1'b0;

        // Ascending, DEPTH=4: two back-to-back batches with no idle cycle between them.
        b_in[0] = 4'd12; b_in[1] = 4'd4; b_in[2] = 4'd4; b_in[3] = 4'd10;
        b_in[4] = 4'd1;  b_in[5] = 4'd2; b_in[6] = 4'd3; b_in[7] = 4'd4;
        b_exp[0] = 4'd4; b_exp[1] = 4'd4; b_exp[2] = 4'd10; b_exp[3] = 4'd12;
        b_exp[4] = 4'd1; b_exp[5] = 4'd2; b_exp[6] = 4'd3;  b_exp[7] = 4'd4;
        for (int bt = 0; bt < 2; bt++) begin
            b_ordy = 1'b0;
            for (int k = 0; k < 4; k++) begin
                b_iv = 1'b1; b_id = b_in[bt*4+k];
                @(negedge clk);
                check($sformatf("asc_b%0d_in_ready%0d", bt, k), 32'(b_ir), 32'd1);
                check($sformatf("asc_b%0d_load_valid%0d", bt, k), 32'(b_ov), 32'd0);
                @(posedge clk);
                #1;
            end
            b_iv = 1'b0; b_ordy = 1'b1;
            for (int k = 0; k < 4; k++) begin
                @(negedge clk);
                check($sformatf("asc_b%0d_out_valid%0d", bt, k), 32'(b_ov), 32'd1);
                check($sformatf("asc_b%0d_out_data%0d", bt, k), 32'(b_od), 32'(b_exp[bt*4+k]));
                check($sformatf("asc_b%0d_out_last%0d", bt, k), 32'(b_ol), (k == 3) ? 32'd1 : 32'd0);
                @(posedge clk);
                #1;
            end
        end
        b_ordy = 1'b0;
        @(negedge clk);
        check("asc_after_in_ready", 32'(b_ir), 32'd1);
        check("asc_after_out_valid", 32'(b_ov), 32'd0);
        @(posedge clk);
        #1;

        // Randomized batches on the WIDTH=8 DEPTH=8 pair, checked cycle by cycle.
        loading = 1'b1; pos = 0; done = 0; cyc = 0;
        words.delete();
        while (done < 200 && cyc < 30000) begin
            r_iv   = ($urandom_range(0, 3) != 0);
            r_id   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 3) * 85) : 8'($urandom_range(0, 255));
            r_ordy = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            check("rnd_dn_in_ready",  32'(c_ir), 32'(loading));
            check("rnd_up_in_ready",  32'(e_ir), 32'(loading));
            check("rnd_dn_out_valid", 32'(c_ov), 32'(!loading));
            check("rnd_up_out_valid", 32'(e_ov), 32'(!loading));
            check("rnd_dn_out_last",  32'(c_ol), 32'(!loading && pos == 7));
            check("rnd_up_out_last",  32'(e_ol), 32'(!loading && pos == 7));
            if (!loading) begin
                check($sformatf("rnd_dn_b%0d_w%0d", done, pos), 32'(c_od), 32'(exp_dn[pos]));
                check($sformatf("rnd_up_b%0d_w%0d", done, pos), 32'(e_od), 32'(exp_up[pos]));
            end
            @(posedge clk);
            #1;
            cyc++;
            if (loading) begin
                if (r_iv) begin
                    words.push_back(r_id);
                    if (words.size() == 8) begin
                        exp_dn  = ranked(words, 1'b0);
                        exp_up  = ranked(words, 1'b1);
                        loading = 1'b0;
                        pos     = 0;
                    end
                end
            end else if (r_ordy) begin
                pos++;
                if (pos == 8) begin
                    loading = 1'b1;
                    pos     = 0;
                    done++;
                    words.delete();
                end
            end
        end
        check("rnd_batches_completed", 32'(done), 32'd200);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ordenador_serial.md
# ordenador_serial

Parametrised streaming sorter. It accepts a batch of DEPTH unsigned words over a valid/ready input, keeps them ordered as they arrive by inserting each word in a single cycle, then emits the batch in sorted order over a valid/ready output. It generalises the team's fixed three-input combinational sorter to any width, batch size and sort direction, with flow control on both sides. It sits between a word producer and any consumer that needs ranked values, for example largest-first.

## Interface
- WIDTH, 4, data word width in bits (≥1)
- DEPTH, 3, words per batch (≥2)
- ORDER, 0, 0 = descending (largest first), 1 = ascending (smallest first)

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  producer offers in_data
- in_data  in  WIDTH  unsigned input word
- in_ready  out  1  block accepts a word this cycle
- out_valid  out  1  out_data holds a sorted word
- out_data  out  WIDTH  current sorted word
- out_ready  in  1  consumer takes out_data this cycle
- out_last  out  1  out_data is the final word of the batch

## Operation
- Storage: buf[0..DEPTH-1] of WIDTH bits; cnt of $clog2(DEPTH+1) bits; idx of $clog2(DEPTH) bits; state ∈ {LOAD, EMIT}.
- Reset values: state = LOAD, cnt = 0, idx = 0, buf all 0. Resulting outputs: in_ready = 1, out_valid = 0, out_last = 0, out_data = 0.
- in_ready = (state == LOAD). out_valid = (state == EMIT). out_data = buf[idx]. out_last = out_valid && idx == DEPTH-1.
- LOAD, on accept (in_valid && in_ready):
  - Let the valid entries be buf[0..cnt-1].
  - Insertion point p:
    - ORDER=0: p = number of valid entries e with e ≥ in_data.
    - ORDER=1: p = number of valid entries e with e ≤ in_data.
  - Update: buf[j+1] ← buf[j] for p ≤ j < cnt; buf[p] ← in_data; cnt ← cnt + 1.
  - Ties are stable: an equal word is placed after earlier equal words.
  - Entries at index ≥ cnt are never compared.
- LOAD → EMIT when the accept brings cnt to DEPTH. cnt stays at DEPTH during EMIT.
- EMIT, on take (out_valid && out_ready):
  - If idx < DEPTH-1: idx ← idx + 1.
  - If idx == DEPTH-1: state ← LOAD, idx ← 0, cnt ← 0.
- With out_ready low, out_data, out_last and out_valid hold steady.
- in_valid is ignored in EMIT. No word is accepted or lost, and in_data is not sampled.
- out_ready is ignored in LOAD.
- Comparisons are unsigned and full WIDTH. There is no arithmetic beyond the cnt/idx increments, and neither counter wraps inside a batch.

## Timing
- Insertion latency: 1 cycle. A word accepted at edge n is in buf after edge n.
- First sorted word: out_valid rises the cycle after the DEPTH-th accept.
- Throughput:
  - Input: 1 word/cycle during LOAD.
  - Output: 1 word/cycle while out_ready is held high.
  - Batch period: 2·DEPTH cycles under no backpressure.
- Back-to-back batches: in_ready rises the cycle after the last take, so the first word of the next batch can be accepted then. There is no overlap between input and output of different batches.
- rst asserted in any state, including mid-LOAD or mid-EMIT, restores all reset values at that edge. Partial batches are discarded and out_valid drops the following cycle.
- in_ready and out_valid are functions of registered state only. There is no combinational path from in_valid or out_ready.

## Test plan
- WIDTH=4, DEPTH=3, ORDER=0: send 5, 9, 2 with out_ready=1 → out_data 9, 5, 2 on 3 consecutive cycles; out_last only with 2; in_ready=1 the next cycle.
- Ties and extremes, WIDTH=4, DEPTH=3: send 7, 0, 7, then 15, 15, 15 → outputs 7, 7, 0, then 15, 15, 15. The cnt/idx paths must not disturb values.
- Backpressure, DEPTH=3, after inputs 3, 1, 2:
  - Hold out_ready=0 for 4 cycles → out_valid=1 and out_data=3 stable throughout.
  - Pulse out_ready → 3, 2, 1.
  - Assert in_valid with in_data=8 during EMIT → 8 never appears.
- ORDER=1, DEPTH=4, WIDTH=4: send 12, 4, 4, 10 → outputs 4, 4, 10, 12. Then send 1, 2, 3, 4 → outputs 1, 2, 3, 4, accepting the first new word one cycle after the previous out_last take.
- Reset mid-operation, DEPTH=3, WIDTH=4:
  - Accept 6, 3, then assert rst for 1 cycle → in_ready=1, out_valid=0, cnt=0.
  - Then send 1, 8, 5 → outputs 8, 5, 1.
  - Repeat with rst during EMIT after the first take → same recovery.
- Random check, WIDTH=8, DEPTH=8, both ORDER values: 200 random batches with random in_valid and out_ready gaps. The output sequence must equal a stable-sorted reference model, out_last must assert exactly once per batch, and no words may be dropped or duplicated.
